// File: rtl/reg_dump_load_ctrl_pkg.sv
// Shared constants and state encoding for the register dump/load controller.
// Default widths are used by the controller and by the register file beside it.
package reg_dump_load_ctrl_pkg;

    localparam int DEF_ADDR_W   = 1;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMP_RD,
        ST_DUMP_OUT,
        ST_LOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/reg_dump_load_ctrl.sv
// Walks a register file: dumps every register onto a valid/ready stream,
// or loads a valid-only stream into the registers in index order.
module reg_dump_load_ctrl
    import reg_dump_load_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic last;

    assign last      = (idx_q == LAST);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_LOAD);
    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    // Next-state and registered-output logic for the walk FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = mode ? ST_LOAD : ST_DUMP_RD;
                end
            end
            ST_DUMP_RD: begin
                out_data_d  = rd_data;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                state_d     = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ONE;
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = in_data;
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any walk in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_reg_dump_load_ctrl.sv
// Bench for reg_dump_load_ctrl: a register file sits beside the DUT and the
// expected dump contents come from what the bench itself loaded or preloaded.
module tb_reg_dump_load_ctrl;

    localparam int AW = 1;
    localparam int DW = 8;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0]    rf [NR];
    logic [AW+DW-1:0] dump_q [$];
    logic [AW+DW-1:0] wr_q [$];
    int               done_cnt;

    reg_dump_load_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_REGS(NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data)
    );

    always #5 clk = ~clk;

    // Register file instantiated alongside the controller.
    assign rd_data = rf[rd_addr];
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end

    // Observe transfers mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) dump_q.push_back({out_addr, out_data});
        if (wr_en) wr_q.push_back({wr_addr, wr_data});
        if (done) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] b);
        rf[0] <= a;
        rf[1] <= b;
        #1;
    endtask

    task automatic run_dump(input int rdy_pct, input bit noise, output bit to);
        dump_q.delete();
        done_cnt = 0;
        start = 1'b1;
        mode = 1'b0;
        step();
        to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (done_cnt != 0) begin
                to = 1'b0;
                break;
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            start = noise;
            mode = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_load(input logic [DW-1:0] d [NR], input int gap_pct,
                            output bit to);
        wr_q.delete();
        done_cnt = 0;
        start = 1'b1;
        mode = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            for (int g = 0; g < 6; g++) begin
                if ($urandom_range(0, 99) >= gap_pct) break;
                in_valid = 1'b0;
                in_data = 8'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data = d[i];
            step();
            in_valid = 1'b0;
        end
        to = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (done_cnt != 0) begin
                to = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [3*DW+16:0] v;
        reset = 1'b1;
        step();
        step();
        v = {busy, done, out_valid, out_data, out_addr, wr_en, wr_addr,
             wr_data, in_ready, rd_addr};
        checks++;
        if (v !== '0) begin
            errs++;
            $display("FAIL reset_outs: got %h want 0", v);
        end
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: busy=%b in_ready=%b want 0 0",
                     busy, in_ready);
        end
    endtask

    task automatic test_dump();
        bit to;
        logic [DW-1:0] e [NR];
        e[0] = 8'h3C;
        e[1] = 8'hA5;
        preload(e[0], e[1]);
        run_dump(100, 1'b0, to);
        checks++;
        if (to || dump_q.size() != NR) begin
            errs++;
            $display("FAIL dump_count: got %0d words to=%b want %0d",
                     dump_q.size(), to, NR);
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (i >= dump_q.size() || dump_q[i] !== {AW'(i), e[i]}) begin
                errs++;
                $display("FAIL dump_word%0d: got %h want %h", i,
                         (i < dump_q.size()) ? dump_q[i] : 'x, {AW'(i), e[i]});
            end
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL dump_done: done=%0d busy=%b want 1 0",
                     done_cnt, busy);
        end
    endtask

    task automatic test_dump_stall();
        logic ok;
        preload(8'h3C, 8'hA5);
        dump_q.delete();
        wr_q.delete();
        done_cnt = 0;
        out_ready = 1'b0;
        start = 1'b1;
        mode = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL stall_rd: valid=%b busy=%b want 0 1",
                     out_valid, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_addr !== 1'b0) begin
            errs++;
            $display("FAIL stall_first: v=%b d=%h a=%h want 1 3c 0",
                     out_valid, out_data, out_addr);
        end
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_addr !== 1'b0)
                ok = 1'b0;
        end
        checks++;
        if (!ok || wr_q.size() != 0) begin
            errs++;
            $display("FAIL stall_hold: v=%b d=%h writes=%0d want 1 3c 0",
                     out_valid, out_data, wr_q.size());
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && done_cnt == 0; n++) step();
        out_ready = 1'b0;
        checks++;
        if (dump_q.size() != 2 || dump_q[0] !== 9'h03C ||
            dump_q[1] !== 9'h1A5 || busy !== 1'b0) begin
            errs++;
            $display("FAIL stall_finish: n=%0d busy=%b want 2 words 03c 1a5",
                     dump_q.size(), busy);
        end
    endtask

    task automatic test_load();
        bit to;
        logic [DW-1:0] d [NR];
        d[0] = 8'h11;
        d[1] = 8'h7F;
        preload(8'h00, 8'h00);
        checks++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL idle_in_ready: got %b want 0", in_ready);
        end
        run_load(d, 60, to);
        checks++;
        if (to || wr_q.size() != 2 || wr_q[0] !== 9'h011 ||
            wr_q[1] !== 9'h17F) begin
            errs++;
            $display("FAIL load_writes: n=%0d to=%b want (0,11) (1,7f)",
                     wr_q.size(), to);
        end
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
            errs++;
            $display("FAIL load_end: wr_en=%b busy=%b done=%0d want 0 0 1",
                     wr_en, busy, done_cnt);
        end
        run_dump(100, 1'b0, to);
        checks++;
        if (to || dump_q.size() != 2 || dump_q[0] !== 9'h011 ||
            dump_q[1] !== 9'h17F) begin
            errs++;
            $display("FAIL load_readback: n=%0d to=%b want 011 17f",
                     dump_q.size(), to);
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        preload(8'hC3, 8'h5A);
        run_dump(40, 1'b1, to);
        checks++;
        if (to || dump_q.size() != NR || done_cnt != 1) begin
            errs++;
            $display("FAIL busy_start: words=%0d done=%0d to=%b want %0d 1",
                     dump_q.size(), done_cnt, to, NR);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0 || dump_q.size() != NR || done_cnt != 1 ||
            dump_q[0] !== 9'h0C3 || dump_q[1] !== 9'h15A) begin
            errs++;
            $display("FAIL busy_after: busy=%b words=%0d done=%0d want 0 2 1",
                     busy, dump_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        bit to;
        logic [3*DW+16:0] v;
        preload(8'h55, 8'h66);
        wr_q.delete();
        done_cnt = 0;
        start = 1'b1;
        mode = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h9A;
        step();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 1'b0 || wr_data !== 8'h9A) begin
            errs++;
            $display("FAIL rst_first_wr: en=%b a=%h d=%h want 1 0 9a",
                     wr_en, wr_addr, wr_data);
        end
        step();
        in_valid = 1'b1;
        in_data = 8'hEE;
        #1;
        reset = 1'b1;
        #1;
        v = {busy, done, out_valid, out_data, out_addr, wr_en, wr_addr,
             wr_data, in_ready, rd_addr};
        checks++;
        if (v !== '0) begin
            errs++;
            $display("FAIL rst_async: got %h want 0", v);
        end
        step();
        step();
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (rf[0] !== 8'h9A || rf[1] !== 8'h66 || wr_q.size() != 1 ||
            busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_regs: r0=%h r1=%h writes=%0d busy=%b want 9a 66 1 0",
                     rf[0], rf[1], wr_q.size(), busy);
        end
        run_dump(100, 1'b0, to);
        checks++;
        if (to || dump_q.size() != 2 || dump_q[0] !== 9'h09A ||
            dump_q[1] !== 9'h166) begin
            errs++;
            $display("FAIL rst_redump: n=%0d to=%b want 09a 166",
                     dump_q.size(), to);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [DW-1:0] d [NR];
        logic [DW-1:0] model [NR];
        int bad;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NR; i++) d[i] = 8'($urandom);
            run_load(d, 50, to);
            for (int i = 0; i < NR; i++) model[i] = d[i];
            bad = 0;
            if (to || wr_q.size() != NR) bad = 1;
            else
                for (int i = 0; i < NR; i++)
                    if (wr_q[i] !== {AW'(i), model[i]}) bad = 1;
            checks++;
            if (bad != 0) begin
                errs++;
                $display("FAIL rnd_load%0d: writes=%0d to=%b data %h %h",
                         r, wr_q.size(), to, model[0], model[1]);
            end
            run_dump($urandom_range(20, 90), 1'($urandom_range(0, 1)), to);
            bad = 0;
            if (to || dump_q.size() != NR || done_cnt != 1) bad = 1;
            else
                for (int i = 0; i < NR; i++)
                    if (dump_q[i] !== {AW'(i), model[i]}) bad = 1;
            checks++;
            if (bad != 0) begin
                errs++;
                $display("FAIL rnd_dump%0d: words=%0d done=%0d want %h %h",
                         r, dump_q.size(), done_cnt, model[0], model[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        done_cnt = 0;
        test_reset();
        test_dump();
        test_dump_stall();
        test_load();
        test_start_while_busy();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
